// File: rtl/line_tracker_ctrl.sv
// Line tracker decision stage: synchronises and debounces three IR line sensors,
// classifies the line position into a motor drive mode and runs the lost-line
// search / timeout state machine. All outputs are registered.
module line_tracker_ctrl #(
  parameter int unsigned STABLE_CYCLES = 100_000,
  parameter int unsigned LOST_TIMEOUT  = 200_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] sensor,
  output logic [2:0] mode,
  output logic       searching,
  output logic       lost
);

  localparam int unsigned DbW = $clog2(STABLE_CYCLES) + 1;
  localparam int unsigned TmW = $clog2(LOST_TIMEOUT) + 1;
  localparam logic [DbW-1:0] DbMax  = DbW'(STABLE_CYCLES);
  localparam logic [TmW-1:0] TmLast = TmW'(LOST_TIMEOUT - 1);

  localparam logic [2:0] ModeStop   = 3'd0;
  localparam logic [2:0] ModeFwd    = 3'd1;
  localparam logic [2:0] ModeTurnL  = 3'd2;
  localparam logic [2:0] ModeTurnR  = 3'd3;
  localparam logic [2:0] ModeSharpL = 3'd4;
  localparam logic [2:0] ModeSharpR = 3'd5;
  localparam logic [2:0] ModeSrchL  = 3'd6;
  localparam logic [2:0] ModeSrchR  = 3'd7;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StTrack  = 2'd1;
  localparam logic [1:0] StSearch = 2'd2;
  localparam logic [1:0] StLost   = 2'd3;

  localparam logic DirLeft  = 1'b0;
  localparam logic DirRight = 1'b1;

  logic [2:0]     sync1_q, sync2_q;
  logic [2:0]     cand_q;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic [2:0]     filt_q, filt_d;

  logic [1:0]     state_q, state_d;
  logic [2:0]     mode_q, mode_d;
  logic           srch_q, srch_d;
  logic           lost_q, lost_d;
  logic [TmW-1:0] timer_q, timer_d;
  logic           dir_q, dir_d;

  logic [2:0]     cls_mode;
  logic           cls_left, cls_right;
  logic           mode_is_track;

  // Two-flop synchroniser per sensor bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= sensor;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive identical samples, saturating at STABLE_CYCLES.
  always_comb begin
    if (sync2_q != cand_q) begin
      db_cnt_d = DbW'(1);
    end else if (db_cnt_q < DbMax) begin
      db_cnt_d = db_cnt_q + DbW'(1);
    end else begin
      db_cnt_d = db_cnt_q;
    end
    filt_d = (db_cnt_d >= DbMax) ? sync2_q : filt_q;
  end

  // Debounce state; runs regardless of en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand_q   <= 3'b000;
      db_cnt_q <= '0;
      filt_q   <= 3'b000;
    end else begin
      cand_q   <= sync2_q;
      db_cnt_q <= db_cnt_d;
      filt_q   <= filt_d;
    end
  end

  // Classify the filtered pattern; 101 holds only a real tracking mode, else FWD.
  always_comb begin
    mode_is_track = (mode_q != ModeStop) && (mode_q < ModeSrchL);
    cls_left      = 1'b0;
    cls_right     = 1'b0;
    case (filt_q)
      3'b010, 3'b111: cls_mode = ModeFwd;
      3'b110: begin
        cls_mode = ModeTurnL;
        cls_left = 1'b1;
      end
      3'b100: begin
        cls_mode = ModeSharpL;
        cls_left = 1'b1;
      end
      3'b011: begin
        cls_mode  = ModeTurnR;
        cls_right = 1'b1;
      end
      3'b001: begin
        cls_mode  = ModeSharpR;
        cls_right = 1'b1;
      end
      3'b101:  cls_mode = mode_is_track ? mode_q : ModeFwd;
      default: cls_mode = ModeStop;
    endcase
  end

  // Next-state logic; en low overrides every other transition.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    srch_d  = srch_q;
    lost_d  = lost_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    if (!en) begin
      state_d = StIdle;
      mode_d  = ModeStop;
      srch_d  = 1'b0;
      lost_d  = 1'b0;
      timer_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StTrack;
          mode_d  = ModeStop;
          srch_d  = 1'b0;
          lost_d  = 1'b0;
        end
        StTrack: begin
          if (filt_q == 3'b000) begin
            state_d = StSearch;
            mode_d  = (dir_q == DirLeft) ? ModeSrchL : ModeSrchR;
            srch_d  = 1'b1;
            timer_d = '0;
          end else begin
            mode_d = cls_mode;
            if (cls_left)  dir_d = DirLeft;
            if (cls_right) dir_d = DirRight;
          end
        end
        StSearch: begin
          // Reacquisition is checked first so it wins over a same-cycle timeout.
          if (filt_q != 3'b000) begin
            state_d = StTrack;
            mode_d  = cls_mode;
            srch_d  = 1'b0;
            timer_d = '0;
            if (cls_left)  dir_d = DirLeft;
            if (cls_right) dir_d = DirRight;
          end else if (timer_q == TmLast) begin
            state_d = StLost;
            mode_d  = ModeStop;
            srch_d  = 1'b0;
            lost_d  = 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TmW'(1);
          end
        end
        StLost: begin
          mode_d = ModeStop;
          srch_d = 1'b0;
          lost_d = 1'b1;
        end
        default: begin
          state_d = StIdle;
          mode_d  = ModeStop;
          srch_d  = 1'b0;
          lost_d  = 1'b0;
          timer_d = '0;
        end
      endcase
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      mode_q  <= ModeStop;
      srch_q  <= 1'b0;
      lost_q  <= 1'b0;
      timer_q <= '0;
      dir_q   <= DirLeft;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      srch_q  <= srch_d;
      lost_q  <= lost_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
    end
  end

  assign mode      = mode_q;
  assign searching = srch_q;
  assign lost      = lost_q;

endmodule

// File: tb/tb_line_tracker_ctrl.sv
// Scoreboard bench for line_tracker_ctrl with STABLE_CYCLES=4, LOST_TIMEOUT=10.
// Stimulus pushes expected {mode,searching,lost} tagged with the clock edge count
// at which they must hold; a monitor compares them on the falling edge.
module tb_line_tracker_ctrl;

  typedef struct {
    int         cyc;
    logic [2:0] mode;
    logic       srch;
    logic       lst;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] sensor;
  logic [2:0] mode;
  logic       searching;
  logic       lost;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  exp_t imm_q[$];
  event chk_now;

  line_tracker_ctrl #(
    .STABLE_CYCLES(4),
    .LOST_TIMEOUT (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sensor   (sensor),
    .mode     (mode),
    .searching(searching),
    .lost     (lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input exp_t e);
    n_vec++;
    if ({mode, searching, lost} !== {e.mode, e.srch, e.lst}) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got mode=%0d searching=%0b lost=%0b, want mode=%0d searching=%0b lost=%0b",
               e.name, cyc, mode, searching, lost, e.mode, e.srch, e.lst);
    end
  endtask

  // Monitor for edge-tagged expectations.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.cyc < cyc) begin
        n_vec++;
        n_fail++;
        $display("FAIL %s: check for edge %0d missed, now at edge %0d", e.name, e.cyc, cyc);
      end else begin
        cmp(e);
      end
    end
  end

  // Monitor for checks that must hold immediately (asynchronous reset).
  always begin
    @(chk_now);
    while (imm_q.size() > 0) begin
      exp_t e;
      e = imm_q.pop_front();
      cmp(e);
    end
  end

  task automatic expect_at(input int cy, input logic [2:0] m, input logic s, input logic l,
                           input string nm);
    exp_t e;
    e.cyc = cy; e.mode = m; e.srch = s; e.lst = l; e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic expect_now(input logic [2:0] m, input logic s, input logic l,
                            input string nm);
    exp_t e;
    e.cyc = cyc; e.mode = m; e.srch = s; e.lst = l; e.name = nm;
    imm_q.push_back(e);
    ->chk_now;
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    rst    = 1'b0;
    en     = 1'b1;
    sensor = 3'b010;
    #2;
    expect_now(3'd0, 1'b0, 1'b0, "reset_state");
    step(3);
    rst = 1'b1;
    c = cyc;
    // Filter still 000 when TRACK is entered, so a brief SEARCH precedes FWD.
    expect_at(c + 6, 3'd6, 1'b1, 1'b0, "startup_pre_latency");
    expect_at(c + 7, 3'd1, 1'b0, 1'b0, "startup_fwd_latency");
    step(8);

    // 3-cycle glitch on 110 must not disturb FWD.
    c = cyc;
    sensor = 3'b110;
    for (int k = 1; k <= 10; k++) expect_at(c + k, 3'd1, 1'b0, 1'b0, "glitch_reject");
    step(3);
    sensor = 3'b010;
    step(8);

    c = cyc;
    sensor = 3'b110;
    expect_at(c + 6, 3'd1, 1'b0, 1'b0, "turn_l_pre");
    expect_at(c + 7, 3'd2, 1'b0, 1'b0, "turn_l");
    step(8);

    c = cyc;
    sensor = 3'b100;
    expect_at(c + 7, 3'd4, 1'b0, 1'b0, "sharp_l");
    step(8);

    // Lose the line: search left, then timeout into LOST_STOP.
    c = cyc;
    sensor = 3'b000;
    expect_at(c + 7,  3'd6, 1'b1, 1'b0, "search_l_entry");
    expect_at(c + 16, 3'd6, 1'b1, 1'b0, "search_l_before_timeout");
    expect_at(c + 17, 3'd0, 1'b0, 1'b1, "lost_stop");
    step(18);

    c = cyc;
    sensor = 3'b010;
    expect_at(c + 8,  3'd0, 1'b0, 1'b1, "lost_sticky_a");
    expect_at(c + 10, 3'd0, 1'b0, 1'b1, "lost_sticky_b");
    step(11);

    c = cyc;
    en = 1'b0;
    expect_at(c + 1, 3'd0, 1'b0, 1'b0, "en_low_idle");
    step(2);
    c = cyc;
    en = 1'b1;
    expect_at(c + 1, 3'd0, 1'b0, 1'b0, "idle_to_track");
    expect_at(c + 2, 3'd1, 1'b0, 1'b0, "rearm_fwd");
    step(3);

    c = cyc;
    sensor = 3'b001;
    expect_at(c + 7, 3'd5, 1'b0, 1'b0, "sharp_r");
    step(8);

    // Search right, reacquire on 011 mid-search.
    c = cyc;
    sensor = 3'b000;
    expect_at(c + 7,  3'd7, 1'b1, 1'b0, "search_r_entry");
    expect_at(c + 11, 3'd7, 1'b1, 1'b0, "search_r_hold");
    expect_at(c + 12, 3'd3, 1'b0, 1'b0, "reacquire_turn_r");
    step(5);
    sensor = 3'b011;
    step(8);

    // Timer restarts from zero on the next search.
    c = cyc;
    sensor = 3'b000;
    expect_at(c + 7,  3'd7, 1'b1, 1'b0, "search_r_again");
    expect_at(c + 16, 3'd7, 1'b1, 1'b0, "search_full_timeout_pre");
    expect_at(c + 17, 3'd0, 1'b0, 1'b1, "search_full_timeout");
    step(18);

    c = cyc;
    en = 1'b0;
    sensor = 3'b110;
    expect_at(c + 1, 3'd0, 1'b0, 1'b0, "en_low_from_lost");
    expect_at(c + 7, 3'd2, 1'b0, 1'b0, "turn_l_after_rearm");
    step(1);
    en = 1'b1;
    step(7);

    // Ambiguous 101 holds TURN_L, then 111 gives FWD.
    c = cyc;
    sensor = 3'b101;
    expect_at(c + 7, 3'd2, 1'b0, 1'b0, "ambig_hold_a");
    expect_at(c + 9, 3'd2, 1'b0, 1'b0, "ambig_hold_b");
    step(10);
    c = cyc;
    sensor = 3'b111;
    expect_at(c + 6, 3'd2, 1'b0, 1'b0, "all_on_pre");
    expect_at(c + 7, 3'd1, 1'b0, 1'b0, "all_on_fwd");
    step(8);

    // Asynchronous reset between edges while searching.
    c = cyc;
    sensor = 3'b000;
    expect_at(c + 7, 3'd6, 1'b1, 1'b0, "search_before_reset");
    step(8);
    #2;
    rst = 1'b0;
    sensor = 3'b010;
    #1;
    expect_now(3'd0, 1'b0, 1'b0, "async_reset_clear");
    @(posedge clk);
    #1;
    rst = 1'b1;
    c = cyc;
    expect_at(c + 6, 3'd6, 1'b1, 1'b0, "post_reset_pre_latency");
    expect_at(c + 7, 3'd1, 1'b0, 1'b0, "post_reset_fwd");
    step(9);

    if (sb_q.size() != 0 || imm_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d checks left, want 0", sb_q.size() + imm_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
